// File: rtl/gate_sweep_sequencer.sv
// ---------------------------------------------------------------------------
// gate_sweep_sequencer
//
// Sweeps every W-bit pattern into a bank of inverters and checks each
// response against the bitwise inverse of the driven pattern. It waits
// SETTLE_CYC cycles before each check, then reports:
//   - a saturating mismatch count,
//   - the first failing pattern,
//   - a pass/fail verdict.
//
// Parameters:
//   W          bank / pattern width (1..8)
//   SETTLE_CYC settle cycles between driving a pattern and checking it (>=1)
//   ERR_W      mismatch counter width
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      level-sampled sweep request, honoured in IDLE or DONE only
//   stim       pattern driven into the inverter bank
//   resp       inverter bank outputs
//   busy       sweep in progress
//   done       sweep finished, held until the next accepted start
//   pass       valid with done, high when no mismatch was counted
//   err_cnt    mismatch count, saturating at all-ones
//   fail_pat   stim value of the first mismatch
//   fail_valid fail_pat holds a captured value
//
// Build option:
//   GATE_SEQ_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep
// ---------------------------------------------------------------------------
module gate_sweep_sequencer #(
    parameter int W          = 4,
    parameter int SETTLE_CYC = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [W-1:0]     stim,
    input  logic [W-1:0]     resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [W-1:0]     fail_pat,
    output logic             fail_valid
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [W:0]       PAT_LAST    = {1'b0, {W{1'b1}}};
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [W:0]       pat_r, pat_nxt_s;
    logic [SW-1:0]    settle_r, settle_nxt_s;
    logic [W-1:0]     stim_r, stim_nxt_s;
    logic [W-1:0]     fail_pat_r, fail_pat_nxt_s;
    logic [ERR_W-1:0] err_r, err_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
    logic             pass_r, pass_nxt_s;
    logic             fail_valid_r, fail_valid_nxt_s;

    logic             start_acc_s;
    logic             mismatch_s;
    logic             last_s;
    logic             settle_end_s;

    // start only counts when the FSM is idle or parked in DONE
    assign start_acc_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign mismatch_s   = (state_r == ST_CHECK) && (resp != ~stim_r);
    assign last_s       = (pat_r == PAT_LAST);
    assign settle_end_s = (settle_r == SETTLE_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) state_nxt_s = ST_DRIVE;
                else       state_nxt_s = state_r;
            end
            ST_DRIVE:  state_nxt_s = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_end_s) state_nxt_s = ST_CHECK;
                else              state_nxt_s = ST_SETTLE;
            end
            ST_CHECK: begin
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
                if (mismatch_s || last_s) state_nxt_s = ST_DONE;
                else                      state_nxt_s = ST_DRIVE;
`else
                if (last_s) state_nxt_s = ST_DONE;
                else        state_nxt_s = ST_DRIVE;
`endif
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered datapath and outputs
    always_comb begin
        pat_nxt_s        = pat_r;
        settle_nxt_s     = settle_r;
        stim_nxt_s       = stim_r;
        err_nxt_s        = err_r;
        fail_pat_nxt_s   = fail_pat_r;
        fail_valid_nxt_s = fail_valid_r;
        busy_nxt_s       = busy_r;
        done_nxt_s       = done_r;
        pass_nxt_s       = pass_r;
        if (start_acc_s) begin
            pat_nxt_s        = '0;
            settle_nxt_s     = '0;
            stim_nxt_s       = '0;
            err_nxt_s        = '0;
            fail_pat_nxt_s   = '0;
            fail_valid_nxt_s = 1'b0;
            busy_nxt_s       = 1'b1;
            done_nxt_s       = 1'b0;
            pass_nxt_s       = 1'b0;
        end else begin
            case (state_r)
                ST_DRIVE: begin
                    stim_nxt_s   = pat_r[W-1:0];
                    settle_nxt_s = '0;
                end
                ST_SETTLE: begin
                    if (settle_end_s) settle_nxt_s = settle_r;
                    else              settle_nxt_s = settle_r + SW'(1);
                end
                ST_CHECK: begin
                    if (mismatch_s) begin
                        if (err_r != ERR_MAX) err_nxt_s = err_r + ERR_W'(1);
                        else                  err_nxt_s = err_r;
                        if (!fail_valid_r) begin
                            fail_pat_nxt_s   = stim_r;
                            fail_valid_nxt_s = 1'b1;
                        end else begin
                            fail_pat_nxt_s   = fail_pat_r;
                            fail_valid_nxt_s = fail_valid_r;
                        end
                    end else begin
                        err_nxt_s = err_r;
                    end
                    if (state_nxt_s == ST_DONE) begin
                        busy_nxt_s = 1'b0;
                        done_nxt_s = 1'b1;
                        stim_nxt_s = '0;
                        // verdict includes the check made on this very edge
                        pass_nxt_s = (err_nxt_s == '0);
                    end else begin
                        // load the next pattern as DRIVE is entered so stim
                        // stays flat across the whole DRIVE/SETTLE/CHECK window
                        pat_nxt_s  = pat_r + (W+1)'(1);
                        stim_nxt_s = pat_nxt_s[W-1:0];
                    end
                end
                default: begin
                    pat_nxt_s = pat_r;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r        <= '0;
            settle_r     <= '0;
            stim_r       <= '0;
            err_r        <= '0;
            fail_pat_r   <= '0;
            fail_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
        end else begin
            pat_r        <= pat_nxt_s;
            settle_r     <= settle_nxt_s;
            stim_r       <= stim_nxt_s;
            err_r        <= err_nxt_s;
            fail_pat_r   <= fail_pat_nxt_s;
            fail_valid_r <= fail_valid_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            pass_r       <= pass_nxt_s;
        end
    end

    assign stim       = stim_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err_cnt    = err_r;
    assign fail_pat   = fail_pat_r;
    assign fail_valid = fail_valid_r;

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// Bench for gate_sweep_sequencer: a behavioural inverter bank with selectable
// faults, a reference sweep model feeding an expected-result queue, and a
// second instance with a 3-bit error counter for saturation.
module tb_gate_sweep_sequencer;

    localparam int W = 4;
    localparam int S = 2;
    localparam int PER = S + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic [3:0] stim, resp, fp, stim2, resp2, fp2;
    logic       busy, done, pass, fv, busy2, done2, pass2, fv2;
    logic [7:0] err;
    logic [2:0] err2;

    int  mode = 0;
    bit  sel = 1'b0;
    int  n_vec = 0;
    int  n_mis = 0;

    typedef struct {
        int lat;
        int err;
        int fp;
        int fv;
        int pass;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // fault modes: 0 ideal, 1 bit2 stuck at 0, 2 bit0 flipped at stim=A, 3 all fail
    function automatic logic [3:0] bank_f(input int m, input logic [3:0] s);
        case (m)
            1:       bank_f = ~s & 4'hB;
            2:       bank_f = (s == 4'hA) ? (~s ^ 4'h1) : ~s;
            3:       bank_f = s;
            default: bank_f = ~s;
        endcase
    endfunction

    assign resp  = bank_f(mode, stim);
    assign resp2 = bank_f(mode, stim2);

    gate_sweep_sequencer #(.W(W), .SETTLE_CYC(S), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .resp(resp),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err),
        .fail_pat(fp), .fail_valid(fv)
    );

    gate_sweep_sequencer #(.W(W), .SETTLE_CYC(S), .ERR_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .stim(stim2), .resp(resp2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .fail_pat(fp2), .fail_valid(fv2)
    );

    logic       o_busy, o_done, o_pass, o_fv;
    logic [3:0] o_stim, o_fp;
    logic [7:0] o_err;
    assign o_busy = sel ? busy2 : busy;
    assign o_done = sel ? done2 : done;
    assign o_pass = sel ? pass2 : pass;
    assign o_fv   = sel ? fv2   : fv;
    assign o_stim = sel ? stim2 : stim;
    assign o_fp   = sel ? fp2   : fp;
    assign o_err  = sel ? {5'd0, err2} : err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int m, input int errmax);
        exp_t e;
        logic [3:0] pv;
        e.err = 0; e.fv = 0; e.fp = 0; e.lat = 16 * PER;
        for (int p = 0; p < 16; p++) begin
            pv = p[3:0];
            if (bank_f(m, pv) != ~pv) begin
                if (e.err < errmax) e.err++;
                if (e.fv == 0) begin
                    e.fv = 1;
                    e.fp = p;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
                    e.lat = (p + 1) * PER;
                    break;
`endif
                end
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic check_result(input string tag, input int cyc);
        exp_t e;
        e = sb.pop_front();
        check_val({tag, "_done"},    32'(o_done), 32'd1);
        check_val({tag, "_latency"}, cyc, e.lat);
        check_val({tag, "_busy"},    32'(o_busy), 32'd0);
        check_val({tag, "_stim"},    32'(o_stim), 32'd0);
        check_val({tag, "_err"},     32'(o_err), e.err);
        check_val({tag, "_fpat"},    32'(o_fp), e.fp);
        check_val({tag, "_fvalid"},  32'(o_fv), e.fv);
        check_val({tag, "_pass"},    32'(o_pass), e.pass);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!o_done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic do_sweep(input string tag, input int m, input bit s, input bit pulses);
        int cyc;
        mode = m;
        sel  = s;
        @(negedge clk);
        if (s) start2 = 1'b1; else start = 1'b1;
        sb.push_back(model(m, s ? 7 : 255));
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
        check_val({tag, "_busy_rise"}, 32'(o_busy), 32'd1);
        cyc = 0;
        while (!o_done && cyc < 400) begin
            if (pulses && (cyc == 10 || cyc == 20)) start = 1'b1;
            else                                    start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check_result(tag, cyc);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_pass", 32'(pass), 32'd0);
        check_val("rst_err",  32'(err),  32'd0);
        check_val("rst_stim", 32'(stim), 32'd0);
        check_val("rst_fv",   32'(fv),   32'd0);
        @(negedge clk) rst_n = 1'b1;

        do_sweep("ideal",   0, 1'b0, 1'b1);
        do_sweep("stuck2",  1, 1'b0, 1'b0);
        do_sweep("faultA",  2, 1'b0, 1'b0);
        do_sweep("sat",     3, 1'b1, 1'b0);
        sel = 1'b0;

        // asynchronous reset in the middle of a faulty sweep
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_done", 32'(done), 32'd0);
        check_val("arst_pass", 32'(pass), 32'd0);
        check_val("arst_err",  32'(err),  32'd0);
        check_val("arst_fpat", 32'(fp),   32'd0);
        check_val("arst_fv",   32'(fv),   32'd0);
        check_val("arst_stim", 32'(stim), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check_val("post_rst_busy", 32'(busy), 32'd0);
        check_val("post_rst_done", 32'(done), 32'd0);
        check_val("post_rst_stim", 32'(stim), 32'd0);

        // start held high: back-to-back sweeps
        mode = 1;
        @(negedge clk) start = 1'b1;
        sb.push_back(model(1, 255));
        @(posedge clk); #1;
        check_val("hold_busy_rise", 32'(busy), 32'd1);
        wait_done(cyc);
        check_result("hold1", cyc);
        sb.push_back(model(1, 255));
        @(posedge clk); #1;
        start = 1'b0;
        check_val("hold_done_1cyc", 32'(done), 32'd0);
        check_val("hold_restart",   32'(busy), 32'd1);
        check_val("hold_err_clr",   32'(err),  32'd0);
        check_val("hold_fv_clr",    32'(fv),   32'd0);
        wait_done(cyc);
        check_result("hold2", cyc);

        check_val("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
